// File: rtl/vx_tcu_sp_pack.sv
// ---------------------------------------------------------------------------
// vx_tcu_sp_pack
//
// Streaming 2:4 structured-sparsity compressor placed in front of the TCU FP
// datapath. Each input beat carries NUM_GROUPS dense groups of 4 FP16
// elements. Per group the two largest-magnitude elements are kept and emitted
// as one packed word, together with a 4-bit keep mask. The masks are also
// packed, one nibble per beat, into per-group metadata words that the TCU
// loads through its sparse-format move op.
//
// Ports
//   clk, reset   clock, asynchronous active-low reset
//   flush        emit the partially filled metadata word (ignored in a cycle
//                that accepts an input beat)
//   in_*         dense beat stream   (valid/ready)
//   out_*        compressed stream   (valid/ready), out_mask per group
//   meta_*       metadata words      (valid/ready), meta_count = nibbles used
//
// Handshake rule for all three streams: a transfer happens on a rising clk
// edge where valid & ready are both 1. A producer holding valid keeps its
// payload stable and never drops valid until that transfer happens; ready
// may change freely.
// ---------------------------------------------------------------------------
module vx_tcu_sp_pack #(
    parameter int NUM_GROUPS = 4,
    parameter int ELEM_W     = 16,
    parameter int META_BEATS = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_GROUPS*4*ELEM_W-1:0]     in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_GROUPS*2*ELEM_W-1:0]     out_data,
    output logic [NUM_GROUPS*4-1:0]            out_mask,
    output logic                               meta_valid,
    input  logic                               meta_ready,
    output logic [NUM_GROUPS*4*META_BEATS-1:0] meta_data,
    output logic [$clog2(META_BEATS):0]        meta_count
);

    localparam int CNT_W  = $clog2(META_BEATS);
    localparam int WORD_W = 4 * META_BEATS;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(META_BEATS - 1);
    localparam logic [CNT_W:0]   COUNT_FULL = (CNT_W + 1)'(META_BEATS);

    logic [CNT_W-1:0]                   cnt;
    logic [NUM_GROUPS*WORD_W-1:0]       acc;
    logic [NUM_GROUPS*WORD_W-1:0]       acc_next;
    logic [NUM_GROUPS*2*ELEM_W-1:0]     sel_data;
    logic [NUM_GROUPS*4-1:0]            sel_mask;
    logic [ELEM_W-1:0]                  ei;
    logic [ELEM_W-1:0]                  ej;
    logic [2:0]                         rank;
    logic                               found_lo;

    logic accept;
    logic meta_stall;
    logic full_load;
    logic flush_load;

    // The last beat of a word must not be taken while the previous word is
    // still waiting for the consumer, otherwise it would have nowhere to go.
    assign meta_stall = meta_valid & ~meta_ready & (cnt == CNT_LAST);
    assign in_ready   = (~out_valid | out_ready) & ~meta_stall;
    assign accept     = in_valid & in_ready;
    assign full_load  = accept & (cnt == CNT_LAST);
    // A flush waits while the metadata slot is occupied and not draining.
    assign flush_load = flush & ~accept & (cnt != '0) & ~(meta_valid & ~meta_ready);

    // Top-2 selection. rank(e) counts the elements that beat e: a larger
    // magnitude, or an equal magnitude at a lower index. Ties therefore
    // always favour the lower index, and exactly two elements get rank < 2.
    always_comb begin
        sel_data = '0;
        sel_mask = '0;
        ei       = '0;
        ej       = '0;
        rank     = '0;
        found_lo = 1'b0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            found_lo = 1'b0;
            for (int e = 0; e < 4; e++) begin
                ei   = in_data[(g*4+e)*ELEM_W +: ELEM_W];
                rank = 3'd0;
                for (int j = 0; j < 4; j++) begin
                    ej = in_data[(g*4+j)*ELEM_W +: ELEM_W];
                    if (j != e) begin
                        if ((ej[ELEM_W-2:0] > ei[ELEM_W-2:0]) ||
                            ((ej[ELEM_W-2:0] == ei[ELEM_W-2:0]) && (j < e))) begin
                            rank = rank + 3'd1;
                        end
                    end
                end
                if (rank < 3'd2) begin
                    sel_mask[g*4+e] = 1'b1;
                    // Elements are visited in index order, so the first kept
                    // one is the low half of the packed word.
                    if (!found_lo) begin
                        sel_data[g*2*ELEM_W +: ELEM_W] = ei;
                        found_lo = 1'b1;
                    end else begin
                        sel_data[g*2*ELEM_W+ELEM_W +: ELEM_W] = ei;
                    end
                end
            end
        end
    end

    // Accumulator with the current beat's masks inserted at nibble cnt.
    always_comb begin
        acc_next = acc;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int k = 0; k < META_BEATS; k++) begin
                if (cnt == CNT_W'(k)) begin
                    acc_next[g*WORD_W + k*4 +: 4] = sel_mask[g*4 +: 4];
                end
            end
        end
    end

    // Compressed data stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_mask  <= sel_mask;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Beat counter and mask accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                acc <= acc_next;
            end
        end else if (flush_load) begin
            cnt <= '0;
            acc <= '0;
        end
    end

    // Metadata output slot. A new word may load in the same cycle the old
    // one is taken; valid then simply stays high with the new payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_valid <= 1'b0;
            meta_data  <= '0;
            meta_count <= '0;
        end else if (full_load) begin
            meta_valid <= 1'b1;
            meta_data  <= acc_next;
            meta_count <= COUNT_FULL;
        end else if (flush_load) begin
            // Unused nibbles are already zero because the accumulator is
            // cleared whenever a word is emitted.
            meta_valid <= 1'b1;
            meta_data  <= acc;
            meta_count <= {1'b0, cnt};
        end else if (meta_ready) begin
            meta_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_tcu_sp_pack.sv
module tb_vx_tcu_sp_pack;

  localparam int NG = 4;
  localparam int EW = 16;
  localparam int MB = 8;
  localparam int IN_W = NG * 4 * EW;
  localparam int OD_W = NG * 2 * EW;
  localparam int OM_W = NG * 4;
  localparam int MD_W = NG * 4 * MB;
  localparam int MC_W = $clog2(MB) + 1;
  localparam int OQ_W = OM_W + OD_W;
  localparam int MQ_W = MC_W + MD_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OD_W-1:0] out_data;
  logic [OM_W-1:0] out_mask;
  logic            meta_valid;
  logic            meta_ready = 1'b1;
  logic [MD_W-1:0] meta_data;
  logic [MC_W-1:0] meta_count;

  vx_tcu_sp_pack #(.NUM_GROUPS(NG), .ELEM_W(EW), .META_BEATS(MB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_data(meta_data), .meta_count(meta_count)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [OQ_W-1:0] out_exp_q[$];
  logic [MQ_W-1:0] meta_exp_q[$];
  logic [OQ_W-1:0] out_exp;
  logic [MQ_W-1:0] meta_exp;
  logic [MD_W-1:0] m_acc = '0;
  int              m_cnt = 0;
  bit              stream_done = 1'b0;

  // Reference selection: pick the best element (lowest index on ties),
  // then the best of the remaining three.
  function automatic logic [4+2*EW-1:0] model_group(input logic [4*EW-1:0] grp);
    logic [EW-2:0]   m [4];
    int              best;
    int              sec;
    int              lo;
    int              hi;
    logic [3:0]      mk;
    logic [2*EW-1:0] w;
    for (int i = 0; i < 4; i++) m[i] = grp[i*EW +: EW-1];
    best = 0;
    for (int i = 1; i < 4; i++) if (m[i] > m[best]) best = i;
    sec = -1;
    for (int i = 0; i < 4; i++) begin
      if (i != best) begin
        if (sec < 0) sec = i;
        else if (m[i] > m[sec]) sec = i;
      end
    end
    mk = 4'b0000;
    mk[best] = 1'b1;
    mk[sec] = 1'b1;
    lo = (best < sec) ? best : sec;
    hi = (best < sec) ? sec : best;
    w = {grp[hi*EW +: EW], grp[lo*EW +: EW]};
    return {mk, w};
  endfunction

  task automatic model_accept(input logic [IN_W-1:0] d);
    logic [OM_W-1:0]    mk;
    logic [OD_W-1:0]    dt;
    logic [4+2*EW-1:0]  r;
    for (int g = 0; g < NG; g++) begin
      r = model_group(d[g*4*EW +: 4*EW]);
      mk[g*4 +: 4] = r[2*EW +: 4];
      dt[g*2*EW +: 2*EW] = r[2*EW-1:0];
      m_acc[g*4*MB + m_cnt*4 +: 4] = r[2*EW +: 4];
    end
    out_exp_q.push_back({mk, dt});
    m_cnt++;
    if (m_cnt == MB) begin
      meta_exp_q.push_back({MC_W'(MB), m_acc});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    if (m_cnt > 0) begin
      meta_exp_q.push_back({MC_W'(m_cnt), m_acc});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  function automatic logic [EW-1:0] rand_elem();
    logic [EW-1:0] v;
    v = EW'($urandom);
    // Half the elements come from a tiny magnitude set to provoke ties.
    if ($urandom_range(0, 1) == 1) v[EW-2:0] = {3'($urandom_range(0, 3)), 12'h000};
    return v;
  endfunction

  function automatic logic [4*EW-1:0] rand_group();
    return {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
  endfunction

  function automatic logic [IN_W-1:0] mk_beat(input logic [4*EW-1:0] g0, input logic [4*EW-1:0] g1);
    return {rand_group(), rand_group(), g1, g0};
  endfunction

  // Output monitor: compares every transfer against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h", {out_mask, out_data});
        end else begin
          out_exp = out_exp_q.pop_front();
          if ({out_mask, out_data} !== out_exp) begin
            errors++;
            $display("FAIL out_beat got %h exp %h", {out_mask, out_data}, out_exp);
          end
        end
      end
      if (meta_valid && meta_ready) begin
        checks++;
        if (meta_exp_q.size() == 0) begin
          errors++;
          $display("FAIL meta_unexpected got %h", {meta_count, meta_data});
        end else begin
          meta_exp = meta_exp_q.pop_front();
          if ({meta_count, meta_data} !== meta_exp) begin
            errors++;
            $display("FAIL meta_word got %h exp %h", {meta_count, meta_data}, meta_exp);
          end
        end
      end
    end
  end

  // driver: present one beat until accepted; call and return at posedge+1
  task automatic send_beat(input logic [IN_W-1:0] d, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    in_data = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        model_accept(d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 exp accept within 200 cycles");
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    model_flush();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (out_exp_q.size() != 0 || meta_exp_q.size() != 0); t++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, meta_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valids got %b exp 00", {out_valid, meta_valid});
    end
    checks++;
    if ({out_data, out_mask} !== '0) begin
      errors++;
      $display("FAIL reset_out got %h exp 0", {out_data, out_mask});
    end
    checks++;
    if ({meta_data, meta_count} !== '0) begin
      errors++;
      $display("FAIL reset_meta got %h exp 0", {meta_data, meta_count});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_select();
    logic [4*EW-1:0] vec [3];
    logic [3:0]      emask [3];
    logic [2*EW-1:0] eword [3];
    int              cyc;
    vec[0] = {16'h0000, 16'h3800, 16'hC000, 16'h3C00}; emask[0] = 4'b0011; eword[0] = 32'hC0003C00;
    vec[1] = {16'h4400, 16'h0000, 16'hBC00, 16'h0000}; emask[1] = 4'b1010; eword[1] = 32'h4400BC00;
    vec[2] = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; emask[2] = 4'b0011; eword[2] = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      send_beat(mk_beat(vec[i], rand_group()), cyc);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL select_latency_%0d got out_valid=%b exp 1", i, out_valid);
      end
      checks++;
      if (out_mask[3:0] !== emask[i]) begin
        errors++;
        $display("FAIL select_mask_%0d got %b exp %b", i, out_mask[3:0], emask[i]);
      end
      checks++;
      if (out_data[31:0] !== eword[i]) begin
        errors++;
        $display("FAIL select_word_%0d got %h exp %h", i, out_data[31:0], eword[i]);
      end
      @(posedge clk);
      #1;
    end
    do_flush();
    drain();
  endtask

  task automatic test_full_word();
    logic [4*EW-1:0] g0;
    logic [4*EW-1:0] g1;
    int              cyc;
    g0 = {16'h0000, 16'h0000, 16'h3C00, 16'h4000};
    g1 = {16'h3C00, 16'h4000, 16'h1000, 16'h1000};
    for (int i = 0; i < 7; i++) send_beat(mk_beat(g0, g1), cyc);
    @(negedge clk);
    checks++;
    if (meta_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_early_meta got %b exp 0", meta_valid);
    end
    @(posedge clk);
    #1;
    send_beat(mk_beat(g0, g1), cyc);
    @(negedge clk);
    checks++;
    if ({out_valid, meta_valid} !== 2'b11) begin
      errors++;
      $display("FAIL full_meta_with_out got %b exp 11", {out_valid, meta_valid});
    end
    checks++;
    if (meta_data[63:0] !== 64'hCCCCCCCC_33333333) begin
      errors++;
      $display("FAIL full_words got %h exp cccccccc33333333", meta_data[63:0]);
    end
    checks++;
    if (meta_count !== MC_W'(8)) begin
      errors++;
      $display("FAIL full_count got %0d exp 8", meta_count);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_flush();
    logic [4*EW-1:0] g0;
    int              cyc;
    g0 = {16'h0000, 16'h4000, 16'h0000, 16'h4000};
    for (int i = 0; i < 3; i++) send_beat(mk_beat(g0, rand_group()), cyc);
    do_flush();
    @(negedge clk);
    checks++;
    if (meta_valid !== 1'b1 || meta_data[31:0] !== 32'h00000555 || meta_count !== MC_W'(3)) begin
      errors++;
      $display("FAIL flush_partial got v=%b w=%h c=%0d exp v=1 w=00000555 c=3", meta_valid, meta_data[31:0], meta_count);
    end
    @(posedge clk);
    #1;
    // next beat starts a fresh word at nibble 0
    send_beat(mk_beat({16'h0000, 16'h3800, 16'hC000, 16'h3C00}, rand_group()), cyc);
    do_flush();
    @(negedge clk);
    checks++;
    if (meta_data[31:0] !== 32'h00000003 || meta_count !== MC_W'(1)) begin
      errors++;
      $display("FAIL flush_fresh got w=%h c=%0d exp w=00000003 c=1", meta_data[31:0], meta_count);
    end
    @(posedge clk);
    #1;
    // flush with nothing accumulated produces no word
    flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (meta_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got meta_valid=%b exp 0", meta_valid);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_meta_stall();
    logic [IN_W-1:0] d16;
    int              cyc;
    meta_ready = 1'b0;
    for (int i = 0; i < 15; i++) send_beat(mk_beat(rand_group(), rand_group()), cyc);
    d16 = mk_beat(rand_group(), rand_group());
    in_data = d16;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || meta_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got in_ready=%b meta_valid=%b exp 0 1", in_ready, meta_valid);
      end
    end
    @(posedge clk);
    #1;
    meta_ready = 1'b1;
    send_beat(d16, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL stall_release got %0d cycles exp 1", cyc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int cyc;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(mk_beat(rand_group(), rand_group()), cyc);
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
          meta_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    meta_ready = 1'b1;
    @(posedge clk);
    #1;
    do_flush();
    drain();
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 5; i++) send_beat(mk_beat(rand_group(), rand_group()), cyc);
    out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got out_valid=%b exp 1", out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, meta_valid} !== 2'b00 || {out_data, out_mask} !== '0 || {meta_data, meta_count} !== '0) begin
      errors++;
      $display("FAIL rmid_clear got ov=%b mv=%b od=%h om=%h", out_valid, meta_valid, out_data, out_mask);
    end
    checks++;
    if (meta_exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_meta_pending got %0d exp 0", meta_exp_q.size());
    end
    out_exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({out_valid, meta_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rmid_spurious got %b exp 00", {out_valid, meta_valid});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send_beat(mk_beat(rand_group(), rand_group()), cyc);
    drain();
  endtask

  initial begin
    test_reset();
    test_select();
    test_full_word();
    test_flush();
    test_meta_stall();
    test_back_to_back();
    test_reset_mid();
    drain();
    checks++;
    if (out_exp_q.size() != 0 || meta_exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain got out=%0d meta=%0d pending exp 0 0", out_exp_q.size(), meta_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
